iou_mmio: RTL and testbench

Parametrised memory-mapped I/O unit on the CPU's io bus (`io_addr`, `io_dout`, `io_we`, `io_rd`, `io_din`), clocked by `cpu_clk` alongside the pipelined CPU.

- Debounces the `data`/`del` buttons and builds a hex input word from switch edges.
- Provides an input-ready status handshake that clears on read.
- Drives the LEDs and a time-multiplexed 7-segment display with leading-zero blanking.
- Generalises the fixed 16-switch / 8-digit I/O unit to configurable widths, digit count, debounce and scan rates.

---
 rtl/iou_mmio.sv | 237 +++++++++++++++++++++++
 tb/tb_iou_mmio.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iou_mmio.sv
// iou_mmio: memory-mapped I/O unit with debounced buttons, hex switch entry,
// LED register and a scanned 7-segment display with leading-zero blanking.
module iou_mmio #(
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter int unsigned SCAN_DIV     = 1024,
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned SW_W         = 16,
   parameter int unsigned LED_W        = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              data,
   input  logic              del,
   input  logic [SW_W-1:0]   x,
   output logic [LED_W-1:0]  led,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   input  logic [7:0]        io_addr,
   input  logic [31:0]       io_dout,
   input  logic              io_we,
   input  logic              io_rd,
   output logic [31:0]       io_din
);

   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [7:0] A_LED    = 8'h00;
   localparam logic [7:0] A_DISP   = 8'h04;
   localparam logic [7:0] A_STATUS = 8'h08;
   localparam logic [7:0] A_IN     = 8'h0C;
   localparam logic [7:0] A_SW     = 8'h10;
   localparam logic [7:0] A_CYC    = 8'h14;

   // synchronisers and edge history
   logic [SW_W-1:0]             r_x_s1, r_x_s2, r_x_prev;
   logic [1:0]                  r_btn_s1, r_btn_s2;
   // debounce state; bit 0 = data, bit 1 = del
   logic [1:0]                  r_btn_stable, r_press;
   logic [1:0][CNT_W-1:0]       r_btn_cnt;
   // bus-visible registers
   logic [LED_W-1:0]            r_led;
   logic [31:0]                 r_disp, r_in, r_edit, r_cyc;
   logic                        r_in_ready, r_edit_active;
   // display scan
   logic [SLOT_W-1:0]           r_slot;
   logic [IDX_W-1:0]            r_idx;
   logic [DIGITS-1:0]           r_an;
   logic [6:0]                  r_seg;

   logic [SW_W-1:0]             w_x_rise;
   logic                        w_dig_vld;
   logic [3:0]                  w_dig;
   logic                        w_rd_in;
   logic [31:0]                 w_src, w_hi;
   logic [IDX_W+1:0]            w_shift;
   logic                        w_blank;
   logic [6:0]                  w_pat;

   assign led = r_led;
   assign an  = r_an;
   assign seg = r_seg;

   // two-flop synchronisers for all asynchronous inputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_x_s1   <= '0;
         r_x_s2   <= '0;
         r_x_prev <= '0;
         r_btn_s1 <= '0;
         r_btn_s2 <= '0;
      end else begin
         r_x_s1   <= x;
         r_x_s2   <= r_x_s1;
         r_x_prev <= r_x_s2;
         r_btn_s1 <= {del, data};
         r_btn_s2 <= r_btn_s1;
      end
   end

   // button debounce: accept a level after DEBOUNCE_CYC consecutive disagreeing cycles
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_btn_stable <= '0;
         r_press      <= '0;
         r_btn_cnt    <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            r_press[b] <= 1'b0;
            if (r_btn_s2[b] != r_btn_stable[b]) begin
               if (r_btn_cnt[b] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                  r_btn_stable[b] <= r_btn_s2[b];
                  r_press[b]      <= r_btn_s2[b];
                  r_btn_cnt[b]    <= '0;
               end else begin
                  r_btn_cnt[b] <= r_btn_cnt[b] + CNT_W'(1);
               end
            end else begin
               r_btn_cnt[b] <= '0;
            end
         end
      end
   end

   // switch rising edges, lowest index wins
   always_comb begin
      w_x_rise  = r_x_s2 & ~r_x_prev;
      w_dig_vld = 1'b0;
      w_dig     = 4'd0;
      for (int i = int'(SW_W) - 1; i >= 0; i--) begin
         if (w_x_rise[i]) begin
            w_dig_vld = 1'b1;
            w_dig     = 4'(i);
         end
      end
   end

   assign w_rd_in = io_rd && (io_addr == A_IN);

   // CPU-writable registers and cycle counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_led  <= '0;
         r_disp <= '0;
         r_cyc  <= '0;
      end else begin
         r_cyc <= r_cyc + 32'd1;
         if (io_we) begin
            case (io_addr)
               A_LED:   r_led  <= io_dout[LED_W-1:0];
               A_DISP:  r_disp <= io_dout;
               default: ;
            endcase
         end
      end
   end

   // edit register, committed value and ready handshake (data > del > digit)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_edit        <= '0;
         r_edit_active <= 1'b0;
         r_in          <= '0;
         r_in_ready    <= 1'b0;
      end else begin
         if (r_press[0]) begin
            r_in          <= r_edit;
            r_in_ready    <= 1'b1;
            r_edit        <= '0;
            r_edit_active <= 1'b0;
         end else begin
            if (w_rd_in) begin
               r_in_ready <= 1'b0;
            end
            if (r_press[1]) begin
               r_edit        <= {4'd0, r_edit[31:4]};
               r_edit_active <= 1'b1;
            end else if (w_dig_vld) begin
               r_edit        <= {r_edit[27:0], w_dig};
               r_edit_active <= 1'b1;
            end
         end
      end
   end

   // slot counter and digit index
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_slot <= '0;
         r_idx  <= '0;
      end else if (r_slot == SLOT_W'(SCAN_DIV - 1)) begin
         r_slot <= '0;
         r_idx  <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
         r_slot <= r_slot + SLOT_W'(1);
      end
   end

   // current digit nibble and blanking decision
   always_comb begin
      w_src   = r_edit_active ? r_edit : r_disp;
      w_shift = {r_idx, 2'b00};
      w_hi    = w_src >> w_shift;
      w_blank = (r_idx != '0) && (w_hi == 32'd0);
   end

   // hex to active-low segments, seg[0]=a .. seg[6]=g
   always_comb begin
      w_pat = 7'h7F;
      case (w_hi[3:0])
         4'h0: w_pat = 7'h40;
         4'h1: w_pat = 7'h79;
         4'h2: w_pat = 7'h24;
         4'h3: w_pat = 7'h30;
         4'h4: w_pat = 7'h19;
         4'h5: w_pat = 7'h12;
         4'h6: w_pat = 7'h02;
         4'h7: w_pat = 7'h78;
         4'h8: w_pat = 7'h00;
         4'h9: w_pat = 7'h10;
         4'hA: w_pat = 7'h08;
         4'hB: w_pat = 7'h03;
         4'hC: w_pat = 7'h46;
         4'hD: w_pat = 7'h21;
         4'hE: w_pat = 7'h06;
         4'hF: w_pat = 7'h0E;
         default: w_pat = 7'h7F;
      endcase
   end

   // registered digit enables and segments
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_an  <= '1;
         r_seg <= 7'h7F;
      end else begin
         r_an  <= ~(DIGITS'(1) << r_idx);
         r_seg <= w_blank ? 7'h7F : w_pat;
      end
   end

   // read mux, combinational from io_addr
   always_comb begin
      io_din = 32'd0;
      case (io_addr)
         A_LED:    io_din = 32'(r_led);
         A_DISP:   io_din = r_disp;
         A_STATUS: io_din = {30'd0, r_edit_active, r_in_ready};
         A_IN:     io_din = r_in;
         A_SW:     io_din = 32'(r_x_s2);
         A_CYC:    io_din = r_cyc;
         default:  io_din = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_iou_mmio.sv
// tb_iou_mmio: directed plus randomized checks of iou_mmio against a
// transaction-level model of the edit/commit/display behaviour.
module tb_iou_mmio;

   localparam int unsigned DEB  = 4;
   localparam int unsigned SCAN = 4;
   localparam int unsigned DIG  = 8;
   localparam int unsigned SWW  = 16;
   localparam int unsigned LEDW = 16;

   logic            clk;
   logic            rstn;
   logic            data, del;
   logic [SWW-1:0]  x;
   logic [LEDW-1:0] led;
   logic [DIG-1:0]  an;
   logic [6:0]      seg;
   logic [7:0]      io_addr;
   logic [31:0]     io_dout, io_din;
   logic            io_we, io_rd;

   iou_mmio #(
      .DEBOUNCE_CYC(DEB), .SCAN_DIV(SCAN), .DIGITS(DIG), .SW_W(SWW), .LED_W(LEDW)
   ) dut (
      .clk(clk), .rstn(rstn), .data(data), .del(del), .x(x),
      .led(led), .an(an), .seg(seg),
      .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd), .io_din(io_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_edit, m_in, m_disp, m_led;
   logic        m_ready, m_active;

   // active-high gfedcba hex glyphs
   logic [6:0] hex_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      m_edit = 0; m_in = 0; m_disp = 0; m_led = 0; m_ready = 0; m_active = 0;
   endtask

   function automatic logic [6:0] exp_seg(input logic [31:0] src, input int k);
      longint unsigned q;
      q = {32'd0, src} / (64'd1 << (4 * k));
      if (k > 0 && q == 0) return 7'h7F;
      return ~hex_pat[int'(q % 16)];
   endfunction

   task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
      io_addr = a;
      #1;
      v = io_din;
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
      io_addr = a; io_dout = d; io_we = 1'b1;
      @(negedge clk);
      io_we = 1'b0;
   endtask

   task automatic check_status(input string tag);
      logic [31:0] v;
      rd_reg(8'h08, v);
      chk_eq(tag, v, {30'd0, m_active, m_ready});
   endtask

   task automatic check_in(input string tag);
      logic [31:0] v;
      rd_reg(8'h0C, v);
      chk_eq(tag, v, m_in);
   endtask

   // read IN with the strobe, which clears in_ready
   task automatic rd_clear();
      logic [31:0] v;
      io_addr = 8'h0C; io_rd = 1'b1;
      #1;
      v = io_din;
      chk_eq("in_strobe_rd", v, m_in);
      @(negedge clk);
      io_rd = 1'b0;
      m_ready = 0;
   endtask

   // raise a switch mask, check SW readback, drop it again
   task automatic dig_edge(input logic [SWW-1:0] mask);
      logic [31:0] v;
      x = mask;
      tick(4);
      rd_reg(8'h10, v);
      chk_eq("sw_rd", v, 32'(mask));
      x = '0;
      tick(4);
      for (int i = 0; i < int'(SWW); i++) begin
         if (mask[i]) begin
            m_edit   = m_edit * 32'd16 + 32'(i);
            m_active = 1;
            break;
         end
      end
   endtask

   // press and release a button long enough to debounce both ways; b=0 data, b=1 del
   task automatic press(input int b);
      if (b == 0) data = 1'b1; else del = 1'b1;
      tick(DEB + 6);
      data = 1'b0; del = 1'b0;
      tick(DEB + 6);
      if (b == 0) begin
         m_in = m_edit; m_ready = 1; m_edit = 0; m_active = 0;
      end else begin
         m_edit = m_edit / 32'd16; m_active = 1;
      end
   endtask

   // watch two full scans and compare every digit against the model
   task automatic scan_check(input string tag);
      logic [31:0] src;
      logic [DIG-1:0] seen;
      src  = m_active ? m_edit : m_disp;
      seen = '0;
      tick(2);
      for (int c = 0; c < int'(2 * SCAN * DIG); c++) begin
         int k;
         @(negedge clk);
         k = -1;
         for (int j = 0; j < int'(DIG); j++) if (an == ~(DIG'(1) << j)) k = j;
         chk_eq({tag, "_an_onehot"}, 32'(k >= 0), 32'd1);
         if (k >= 0) begin
            chk_eq({tag, "_seg"}, 32'(seg), 32'(exp_seg(src, k)));
            seen[k] = 1'b1;
         end
      end
      chk_eq({tag, "_all_digits"}, 32'(seen), 32'(DIG'('1)));
   endtask

   initial begin
      logic [31:0] v, v2;
      logic        got;
      rstn = 1'b0; data = 0; del = 0; x = '0;
      io_addr = 0; io_dout = 0; io_we = 0; io_rd = 0;
      model_reset();
      tick(3);

      // reset state
      chk_eq("rst_an", 32'(an), 32'h000000FF);
      chk_eq("rst_seg", 32'(seg), 32'h7F);
      chk_eq("rst_led", 32'(led), 32'h0);
      check_status("rst_status");
      rd_reg(8'h14, v);
      chk_eq("rst_cyc", v, 32'd0);

      rstn = 1'b1;
      tick(1);
      chk_eq("first_an", 32'(an), 32'h000000FE);
      chk_eq("first_seg", 32'(seg), 32'h40);
      rd_reg(8'h14, v);
      chk_eq("cyc_first", v, 32'd1);
      tick(1);
      rd_reg(8'h14, v2);
      chk_eq("cyc_step", v2 - v, 32'd1);

      // register writes and unmapped access
      wr_reg(8'h00, 32'h0000A5A5); m_led = 32'h0000A5A5;
      chk_eq("led_port", 32'(led), 32'h0000A5A5);
      wr_reg(8'h04, 32'h00001234); m_disp = 32'h00001234;
      wr_reg(8'h18, 32'hDEADBEEF);
      rd_reg(8'h18, v); chk_eq("unmapped_rd", v, 32'd0);
      rd_reg(8'h03, v); chk_eq("unaligned_rd", v, 32'd0);
      rd_reg(8'h00, v); chk_eq("led_rd", v, m_led);
      rd_reg(8'h04, v); chk_eq("disp_rd", v, m_disp);
      scan_check("disp1234");

      // switch-to-edit latency: edit_active rises on the third edge
      x = SWW'(1) << 3;
      tick(2);
      check_status("sw_lat2");
      tick(1);
      m_edit = 32'h3; m_active = 1;
      check_status("sw_lat3");
      x = '0;
      tick(4);
      dig_edge(SWW'(1) << 10);
      dig_edge((SWW'(1) << 7) | (SWW'(1) << 2));
      chk_eq("model_edit_3a2", m_edit, 32'h3A2);
      scan_check("edit3a2");

      press(1);
      scan_check("edit3a");
      press(0);
      check_in("in_3a");
      check_status("ready_set");
      rd_clear();
      check_status("ready_clr");

      // commit and read strobe in the same cycle: set wins
      dig_edge(SWW'(1) << 7);
      dig_edge(SWW'(1) << 1);
      data = 1'b1; io_addr = 8'h0C; io_rd = 1'b1; got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         #1;
         if (io_din == 32'h71) got = 1'b1;
      end
      io_rd = 1'b0;
      chk_eq("collide_commit_seen", 32'(got), 32'd1);
      m_in = 32'h71; m_ready = 1; m_edit = 0; m_active = 0;
      check_status("collide_status");
      data = 1'b0;
      tick(DEB + 6);

      // glitches shorter than the debounce window are ignored
      data = 1'b1; tick(2); data = 1'b0; tick(DEB + 6);
      del  = 1'b1; tick(2); del  = 1'b0; tick(DEB + 6);
      check_status("glitch_status");
      check_in("glitch_in");

      // randomized traffic against the model
      for (int it = 0; it < 60; it++) begin
         logic [SWW-1:0] mask;
         logic [31:0]    r;
         case ($urandom_range(0, 6))
            0, 1: begin
               mask = SWW'(1) << $urandom_range(0, SWW - 1);
               if ($urandom_range(0, 1) == 1) mask = mask | (SWW'(1) << $urandom_range(0, SWW - 1));
               dig_edge(mask);
            end
            2: press(1);
            3: begin
               press(0);
               check_in("rnd_in");
            end
            4: rd_clear();
            5: begin
               r = $urandom;
               if ($urandom_range(0, 1) == 1) r = r >> (4 * $urandom_range(1, 7));
               wr_reg(8'h04, r); m_disp = r;
               rd_reg(8'h04, v); chk_eq("rnd_disp_rd", v, m_disp);
            end
            default: begin
               r = $urandom;
               wr_reg(8'h00, r); m_led = r & 32'h0000FFFF;
               chk_eq("rnd_led_port", 32'(led), m_led);
               rd_reg(8'h00, v); chk_eq("rnd_led_rd", v, m_led);
            end
         endcase
         check_status("rnd_status");
         if (it % 8 == 7) scan_check("rnd_scan");
      end

      // reset mid-debounce and mid-scan
      data = 1'b1;
      tick(3);
      rstn = 1'b0;
      #1;
      chk_eq("midrst_an", 32'(an), 32'h000000FF);
      chk_eq("midrst_seg", 32'(seg), 32'h7F);
      @(negedge clk);
      data = 1'b0;
      tick(2);
      rstn = 1'b1;
      model_reset();
      tick(DEB + 8);
      check_status("postrst_status");
      check_in("postrst_in");
      chk_eq("postrst_led", 32'(led), 32'h0);
      scan_check("postrst_scan");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
